seq_mul_unit: RTL and testbench
===============================

// Module: seq_mul_unit
// PURPOSE
//  Iterative radix-2 shift-add multiplier that produces mul_result for the
//  execution unit's multiply path (selected when id_ex_enable=0).
//  Sits beside the ALU in EX: takes operands from ID/EX, holds the pipeline
//  via busy while iterating, and presents a stable product with a done pulse.
//  Supports MUL (low word), MULH (signed high word) and MULHU (unsigned high word).
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH bits internally
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        asynchronous, active-high reset
//  start       in   1        request a multiply; sampled on clk rising edge
//  mul_op      in   2        00=MUL low, 01=MULH signed high, 10=MULHU unsigned high, 11=MUL low
//  in1         in   WIDTH    multiplicand (rs1)
//  in2         in   WIDTH    multiplier (rs2)
//  flush       in   1        abort the in-flight operation (branch mispredict)
//  busy        out  1        high while iterating; pipeline stalls on busy
//  done        out  1        one-cycle pulse: mul_result valid for the new op
//  mul_result  out  WIDTH    selected product word; held until the next op completes
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy=0, done=0, mul_result=0, counter=0.
//  FSM states are IDLE, BUSY and DONE.
//   IDLE: start=1 -> latch operands, mul_op and signs; go to BUSY, count=0.
//   BUSY: one add/shift per cycle; count increments; after WIDTH iterations -> DONE.
//   DONE: done=1 for exactly 1 cycle. start=1 -> BUSY with new operands; else -> IDLE.
//  Latency: start seen at edge k -> done high during cycle after edge k+WIDTH+1.
//   busy is high for exactly WIDTH cycles per op.
//  Signed (MULH): multiply magnitudes |in1|,|in2|; negate the 2*WIDTH-bit product
//   on the BUSY->DONE transition if sign(in1)^sign(in2). MUL/MULHU are unsigned
//   throughout; the MUL low word is identical for signed and unsigned.
//  Most-negative operand (0x8000_0000): magnitude is 2^31, held in WIDTH bits
//   unsigned; the result must be correct (e.g. MULH 0x80000000*0x80000000 =
//   0x40000000).
//  mul_result updates only on entry to DONE; otherwise it holds its value.
//   busy/done are registered outputs.
//  start while BUSY: ignored; no queueing. Operands are latched, so later
//   changes to in1/in2 have no effect.
//  flush while BUSY: next state IDLE; busy=0, no done pulse; mul_result unchanged.
//  flush and start in the same cycle in IDLE/DONE: flush wins and start is dropped.
//  flush in DONE: done still reads 1 this cycle; next state IDLE.
// TESTING
//  1. MUL in1=6, in2=7 -> done exactly 33 cycles after start, mul_result=42;
//     busy high for 32 cycles.
//  2. MULH in1=0xFFFFFFFD(-3), in2=5 -> mul_result=0xFFFFFFFF;
//     MUL gives 0xFFFFFFF1.
//  3. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL gives 0x00000001;
//     MULH gives 0x00000000.
//  4. Start 3*4, pulse start again with 9*9 at cycle 10 -> ignored;
//     a single done with mul_result=12.
//  5. Flush at cycle 15 of 100*100 -> busy drops next cycle, no done pulse,
//     mul_result keeps its old value; next start works.
//  6. Assert reset mid-BUSY -> outputs 0 immediately (async); back-to-back start
//     in DONE -> second result after 33 more cycles.

Source files
------------

// File: rtl/seq_mul_unit.sv
// -----------------------------------------------------------------------------
// seq_mul_unit
//   Iterative radix-2 shift-add multiplier for the EX-stage multiply path.
//   It performs one add/shift per clock over WIDTH iterations. After the last
//   iteration there is one finalisation cycle that applies the MULH sign
//   correction. The selected product word is then presented with a one-cycle
//   done pulse. The result stays on mul_result until the next operation
//   completes.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   start       request a multiply (accepted in IDLE or DONE)
//   mul_op      00/11 = MUL low word, 01 = MULH signed high, 10 = MULHU high
//   in1, in2    multiplicand / multiplier, latched when start is accepted
//   flush       abort the in-flight operation; also blocks a same-cycle start
//   busy        high for exactly WIDTH cycles per accepted operation
//   done        one-cycle pulse when mul_result carries the new product
//   mul_result  selected product word, held between completions
// -----------------------------------------------------------------------------
module seq_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mul_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mul_result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_END  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_count;
  logic [1:0]           r_op;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_prod;

  logic                 w_load;
  logic                 w_signed;
  logic                 w_neg;
  logic [WIDTH-1:0]     w_a;
  logic [WIDTH-1:0]     w_b;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_step;

  // Two's-complement magnitude as an unsigned WIDTH-bit value. The most
  // negative input maps onto itself, which read unsigned is exactly 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? (~u + 1'b1) : u;
  endfunction

  // Applies the MULH sign to the full 2*WIDTH product and picks the word.
  // Only MULH ever has neg set, so MULHU and MUL read the raw product.
  function automatic logic [WIDTH-1:0] select_word(input logic [1:0]         op,
                                                   input logic               neg,
                                                   input logic [2*WIDTH-1:0] prod);
    logic [2*WIDTH-1:0] fixed;
    fixed = neg ? (~prod + 1'b1) : prod;
    case (op)
      2'b01:   return fixed[2*WIDTH-1:WIDTH];
      2'b10:   return prod[2*WIDTH-1:WIDTH];
      default: return prod[WIDTH-1:0];
    endcase
  endfunction

  assign w_load   = start && !flush && (r_state == S_IDLE || r_state == S_DONE);
  assign w_signed = (mul_op == 2'b01);
  assign w_neg    = w_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]);
  assign w_a      = w_signed ? magnitude(in1) : in1;
  assign w_b      = w_signed ? magnitude(in2) : in2;

  // The upper half accumulates. The lower half starts as the multiplier and
  // shifts out one LSB per step. The carry of the add lands in the MSB.
  assign w_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_step = {w_sum, r_prod[WIDTH-1:1]};

  // Datapath registers: the control FSM decides when their contents matter.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_mcand <= w_a;
      r_prod  <= {{WIDTH{1'b0}}, w_b};
    end else if (r_state == S_BUSY && r_count != CNT_END) begin
      r_prod  <= w_step;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_op       <= 2'b00;
      r_neg      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mul_result <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_load) begin
            r_state <= S_BUSY;
            r_count <= '0;
            r_op    <= mul_op;
            r_neg   <= w_neg;
            busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (flush) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else if (r_count == CNT_END) begin
            // Finalisation cycle: all iterations are done, so publish the result.
            r_state    <= S_DONE;
            done       <= 1'b1;
            mul_result <= select_word(r_op, r_neg, r_prod);
          end else begin
            r_count <= r_count + 1'b1;
            // busy falls as the last iteration runs. The finalisation
            // cycle therefore reads busy=0.
            busy    <= (r_count != CNT_LAST);
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_unit.sv
module tb_seq_mul_unit;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    mul_op;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic          flush;
  logic          busy;
  logic          done;
  logic [W-1:0]  mul_result;

  seq_mul_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mul_op     (mul_op),
    .in1        (in1),
    .in2        (in2),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .mul_result (mul_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference product straight from 64-bit arithmetic.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic        [63:0] pu;
    logic signed [63:0] ps;
    pu = {32'b0, a} * {32'b0, b};
    ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    case (op)
      2'b01:   return ps[63:32];
      2'b10:   return pu[63:32];
      default: return pu[31:0];
    endcase
  endfunction

  // Behavioural model. An accepted op at edge t0 keeps busy high after
  // edges t0..t0+W-1 and completes at edge t0+W+1. Flush aborts it. Start
  // is only taken when no op is in flight and flush is low.
  bit          m_active = 1'b0;
  int          m_t0     = 0;
  logic [31:0] m_pend   = '0;
  logic [31:0] m_res    = '0;
  logic        m_done   = 1'b0;
  logic        m_busy   = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_active = 1'b0;
        m_res    = '0;
        m_done   = 1'b0;
      end else begin
        m_done = 1'b0;
        if (m_active) begin
          if (flush) begin
            m_active = 1'b0;
          end else if (cyc == m_t0 + W + 1) begin
            m_active = 1'b0;
            m_res    = m_pend;
            m_done   = 1'b1;
          end
        end else if (start && !flush) begin
          m_active = 1'b1;
          m_t0     = cyc;
          m_pend   = ref_mul(mul_op, in1, in2);
        end
      end
      m_busy = m_active && (cyc - m_t0 < W);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("busy", {31'b0, busy}, {31'b0, m_busy});
        chk("done", {31'b0, done}, {31'b0, m_done});
        chk("mul_result", mul_result, m_res);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int t_acc);
    @(negedge clk);
    start  = 1'b1;
    mul_op = op;
    in1    = a;
    in2    = b;
    t_acc  = cyc + 1;
    @(negedge clk);
    start  = 1'b0;
    mul_op = 2'($urandom);
    in1    = $urandom;
    in2    = $urandom;
  endtask

  task automatic wait_done(output int at_cyc, output int busy_cnt);
    at_cyc   = -1;
    busy_cnt = busy ? 1 : 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_lit(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int t, at, bc;
    issue(op, a, b, t);
    wait_done(at, bc);
    chk({nm, "_result"}, mul_result, exp);
  endtask

  initial begin
    int t, at, bc, t2, at2, n_done;
    logic [31:0] held;
    logic [31:0] corners [5];
    corners[0] = 32'h0;
    corners[1] = 32'h1;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;

    reset = 1'b1; start = 1'b0; flush = 1'b0; mul_op = 2'b00; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", mul_result, 32'd0);
    cmp_en = 1'b1;

    // MUL 6*7: latency and busy length
    issue(2'b00, 32'd6, 32'd7, t);
    wait_done(at, bc);
    chk("mul67_latency", 32'(at - t), 32'd33);
    chk("mul67_busy_cycles", 32'(bc), 32'd32);
    chk("mul67_result", mul_result, 32'd42);

    run_lit("mulh_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);
    run_lit("mul_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
    run_lit("mulhu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_lit("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_lit("mulh_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_lit("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_lit("mul_op11", 2'b11, 32'd1000, 32'd3, 32'd3000);

    // start during BUSY is ignored
    issue(2'b00, 32'd3, 32'd4, t);
    repeat (8) @(negedge clk);
    start = 1'b1; in1 = 32'd9; in2 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("ignored_start_dones", 32'(n_done), 32'd1);
    chk("ignored_start_result", mul_result, 32'd12);

    // flush mid-BUSY
    held = mul_result;
    issue(2'b00, 32'd100, 32'd100, t);
    repeat (13) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_drop", {31'b0, busy}, 32'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("flush_no_done", 32'(n_done), 32'd0);
    chk("flush_result_held", mul_result, held);
    run_lit("after_flush", 2'b00, 32'd100, 32'd100, 32'd10000);

    // asynchronous reset mid-BUSY
    issue(2'b00, 32'd5, 32'd5, t);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_done", {31'b0, done}, 32'd0);
    chk("async_rst_result", mul_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // back-to-back: new start issued in the DONE cycle
    issue(2'b00, 32'd11, 32'd11, t);
    wait_done(at, bc);
    chk("b2b_first", mul_result, 32'd121);
    start = 1'b1; mul_op = 2'b01; in1 = 32'hFFFF_FFFE; in2 = 32'h4000_0000;
    t2 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    wait_done(at2, bc);
    chk("b2b_latency", 32'(at2 - t2), 32'd33);
    chk("b2b_second", mul_result, 32'hFFFF_FFFF);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 5) == 0);
      flush  = ($urandom_range(0, 60) == 0);
      mul_op = 2'($urandom);
      in1    = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      in2    = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
